// File: rtl/uart_tx_buffered_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_buffered_if : register-write side and status/line of the TX  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_buffered_if;
  logic [7:0] UART_TXD;
  logic       TX_EN;
  logic       TX_STATUS;
  logic       UART_TX;
  logic       tx_busy;
  logic [4:0] tx_count;
  logic       tx_overflow;

  modport master (
    output UART_TXD, TX_EN,
    input  TX_STATUS, UART_TX, tx_busy, tx_count, tx_overflow
  );

  modport slave (
    input  UART_TXD, TX_EN,
    output TX_STATUS, UART_TX, tx_busy, tx_count, tx_overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_buffered : FIFO-buffered 8N1 UART transmitter (8E1 when the  |
// | UART_TX_PARITY_EN macro is defined).                   Rev 1.0       |
// +----------------------------------------------------------------------+
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  uart_tx_buffered_if.slave bus
);
  localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [15:0]      bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             line, line_n;
  logic             pop;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       count;
  logic             overflow;
  logic             en_d;
  logic             push, push_ok, full, empty, bit_done;
  logic [7:0]       head;
`ifdef UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign push     = bus.TX_EN & ~en_d;
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == 5'd0);
  // A full FIFO still accepts a byte when the same edge frees a slot.
  assign push_ok  = push & (~full | pop);
  assign head     = mem[rd_ptr];
  assign bit_done = (bit_cnt == LAST_CNT);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      en_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      en_d <= bus.TX_EN;
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && !push_ok)
        overflow <= 1'b1;
      if (push_ok && !pop)
        count <= count + 5'd1;
      else if (!push_ok && pop)
        count <= count - 5'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= bus.UART_TXD;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      line    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      line    <= line_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    line_n    = line;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    if (!bit_done)
      bit_cnt_n = bit_cnt + 16'd1;
    else
      bit_cnt_n = 16'd0;

    case (state)
      S_IDLE: begin
        bit_cnt_n = 16'd0;
        line_n    = 1'b1;
        pop       = ~empty;
      end
      S_START: begin
        if (bit_done) begin
          bit_idx_n = 3'd0;
          line_n    = shreg[0];
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            line_n  = par;
            state_n = S_PARITY;
`else
            line_n  = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            line_n    = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          line_n  = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          pop     = ~empty;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n   = S_IDLE;
        bit_cnt_n = 16'd0;
        line_n    = 1'b1;
      end
    endcase

    // Loading the head byte starts a frame from either IDLE or the end of STOP.
    if (pop) begin
      shreg_n   = head;
      line_n    = 1'b0;
      bit_cnt_n = 16'd0;
      bit_idx_n = 3'd0;
      state_n   = S_START;
`ifdef UART_TX_PARITY_EN
      par_n     = ^head;
`endif
    end
  end

  assign bus.UART_TX     = line;
  assign bus.TX_STATUS   = ~full;
  assign bus.tx_busy     = (state != S_IDLE);
  assign bus.tx_count    = count;
  assign bus.tx_overflow = overflow;
endmodule
`default_nettype wire

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter on the `sysclk` domain, downstream of the memory stage's peripheral decode. It accepts bytes written to the UART TX register, queues them in a small FIFO, and serializes them LSB-first as 8N1 frames on `UART_TX`. It reports free space back to the memory-mapped status word through `TX_STATUS`.

## Interface
- `CLKS_PER_BIT`, 10417: `sysclk` cycles per bit (100 MHz / 9600 baud); legal range 2..65535.
- `FIFO_DEPTH`, 4: byte entries; power of two, 2..16.
- `sysclk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `UART_TXD` input 8: byte to transmit; valid while `TX_EN` is high.
- `TX_EN` input 1: write strobe, level; one enqueue per 0→1 transition.
- `TX_STATUS` output 1: 1 = FIFO has space (count < FIFO_DEPTH).
- `UART_TX` output 1: serial line, registered, idle high.
- `tx_busy` output 1: 1 while a frame is on the line (state ≠ IDLE).
- `tx_count` output 5: current FIFO occupancy, 0..FIFO_DEPTH.
- `tx_overflow` output 1: sticky; set when an enqueue is attempted while full.

## Operation
- Edge detect: `en_d` registers `TX_EN`; enqueue request = `TX_EN & ~en_d`. A strobe held high for many cycles enqueues exactly once. `UART_TXD` is captured at the same edge.
- FIFO: circular buffer with wrapping read/write pointers and an explicit count.
  - Enqueue when full: byte dropped, count unchanged, `tx_overflow` ← 1.
  - Enqueue and pop on the same edge (including when full): both occur, count unchanged, no overflow.
- FSM states and transitions:
  - IDLE: if count ≠ 0, pop the head byte into the shift register, `UART_TX` ← 0, go to START.
  - START: when the bit counter reaches CLKS_PER_BIT−1, output data bit 0 and go to DATA.
  - DATA: bits 0..7, LSB first, each held CLKS_PER_BIT cycles. After bit 7, go to PARITY if compiled in, otherwise to STOP. Entering STOP drives `UART_TX` = 1.
  - PARITY: only when compiled in; see Configuration.
  - STOP: held CLKS_PER_BIT cycles. At its end, if count ≠ 0, pop and go directly to START with no idle gap; otherwise go to IDLE with the line high.
- Bit counter: 16 bits, cleared on every state/bit change, never exceeds CLKS_PER_BIT−1.
- Reset values: `UART_TX`=1, `TX_STATUS`=1, `tx_busy`=0, `tx_count`=0, `tx_overflow`=0, state IDLE, pointers 0, `en_d`=0.

## Timing
- Strobe sampled at edge k → `tx_count` increments at edge k. If IDLE, the pop happens and `UART_TX` falls at edge k+1, and `tx_busy` rises at k+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity. Back-to-back frames are contiguous.
- `TX_STATUS` and `tx_count` reflect register state one edge after a push or pop.
- Reset mid-frame: at the reset edge, the line returns high, the frame is truncated, and the FIFO is emptied. No bytes survive reset.
- A strobe present in the reset cycle is ignored. `en_d` is cleared, so a `TX_EN` still high after reset enqueues once.

## Configuration
- `UART_TX_PARITY_EN` defined: adds the PARITY state after bit 7. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving 8E1 frames of 11 bit-times.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; 8N1 frames of 10 bit-times.

## Test plan
- Reset, CLKS_PER_BIT=4, no parity. Pulse TX_EN with 0x55 → line falls one cycle later, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high. `tx_busy` is high for 40 cycles, then `tx_count`=0.
- TX_EN held high for 20 cycles with 0xA3 → exactly one frame sent; `tx_count` peaks at 1 and never reaches 2.
- Five strobes at 2-cycle spacing, FIFO_DEPTH=4, while idle → the first byte is popped immediately and all five frames are sent contiguously. A sixth strobe while 4 are queued and a frame is in progress → `TX_STATUS`=0 beforehand, byte dropped, `tx_overflow`=1 and sticky.
- FIFO full, strobe on the same edge as the stop-bit pop → count stays 4 and `tx_overflow` stays 0.
- Assert reset during data bit 3 of 0xFF with 2 bytes queued → next edge: `UART_TX`=1, `tx_count`=0, `tx_busy`=0, and no further frames.
- With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1 and frame length 44 cycles. Send 0x03 → parity bit 0.
